// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared audio sample types and I2S frame constants
//
// Purpose: common definitions for the mixer and the I2S DAC serializer.
//   SAMPLE_W    : width of one two's-complement, left-justified sample
//   FRAME_SLOTS : bit slots per stereo I2S frame
//   LEFT_SLOTS  : slots per frame with LRCK low (left half)
//   sample_t    : signed sample type
//   stereo_t    : one stereo frame, left in the upper half
package audio_pkg;

  localparam int SAMPLE_W    = 32;
  localparam int FRAME_SLOTS = 64;
  localparam int LEFT_SLOTS  = 32;
  localparam int FRAME_W     = 2 * SAMPLE_W;
  localparam int SLOT_W      = $clog2(FRAME_SLOTS);

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;

  // Wire order of a stereo frame: left MSB first, then right MSB first.
  function automatic logic [FRAME_W-1:0] frame_word(input stereo_t s);
    return {s.left, s.right};
  endfunction

endpackage

// File: rtl/i2s_bclk_gen.sv
// rtl/i2s_bclk_gen.sv - I2S bit-clock divider with slot strobes
//
// Purpose: divides clk into the I2S bit clock. The divider counts
// 0..2*CLK_DIV-1; BCLK is low for the first CLK_DIV counts, high for the rest.
// Ports:
//   clk        in  : system clock
//   resetn     in  : asynchronous active-low reset
//   aud_bclk   out : registered bit clock
//   slot_start out : high in the clk whose edge makes BCLK fall (divider wraps)
//   bclk_rise  out : high in the clk whose edge makes BCLK rise
module i2s_bclk_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic resetn,
  output logic aud_bclk,
  output logic slot_start,
  output logic bclk_rise
);

  localparam int DIV_MAX = 2 * CLK_DIV - 1;
  localparam int DIV_W   = $clog2(2 * CLK_DIV);

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_next;
  logic             r_bclk;

  always_comb begin
    w_div_next = (r_div == DIV_W'(DIV_MAX)) ? '0 : r_div + DIV_W'(1);
  end

  // BCLK is registered from the next divider value so it stays aligned
  // with r_div without a decode glitch on the pin.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else begin
      r_div  <= w_div_next;
      r_bclk <= (w_div_next >= DIV_W'(CLK_DIV));
    end
  end

  assign aud_bclk   = r_bclk;
  assign slot_start = (r_div == DIV_W'(DIV_MAX));
  assign bclk_rise  = (r_div == DIV_W'(CLK_DIV - 1));

endmodule

// File: rtl/i2s_dac_serializer.sv
// rtl/i2s_dac_serializer.sv - I2S master serializer for the board audio DAC
//
// Purpose: buffers one stereo sample over a valid/ready handshake and shifts
// it out MSB-first as a 64-slot I2S frame with the standard one-bit delay.
// Ports:
//   clk          in  : system clock
//   resetn       in  : asynchronous active-low reset
//   left_in      in  : left sample
//   right_in     in  : right sample
//   sample_valid in  : left_in/right_in hold a sample
//   sample_ready out : holding buffer empty
//   aud_bclk     out : I2S bit clock
//   aud_daclrck  out : LR clock, 0 = left, 1 = right
//   aud_dacdat   out : serial data
//   underrun     out : one-clk pulse when a frame loads from an empty buffer
module i2s_dac_serializer
  import audio_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic    clk,
  input  logic    resetn,
  input  sample_t left_in,
  input  sample_t right_in,
  input  logic    sample_valid,
  output logic    sample_ready,
  output logic    aud_bclk,
  output logic    aud_daclrck,
  output logic    aud_dacdat,
  output logic    underrun
);

  logic               w_slot_start;
  logic               w_bclk_rise_unused;
  logic               w_accept;
  logic               w_load;
  logic [SLOT_W-1:0]  w_slot_next;
  logic [FRAME_W-1:0] w_frame;

  logic [SLOT_W-1:0]  r_slot;
  stereo_t            r_buf;
  logic               r_ready;
  logic [FRAME_W-1:0] r_shift;
  logic               r_lrck;
  logic               r_dat;
  logic               r_underrun;

  // Data and LRCK change on BCLK fall, so the rising-edge strobe is not needed.
  i2s_bclk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_bclk_gen (
    .clk        (clk),
    .resetn     (resetn),
    .aud_bclk   (aud_bclk),
    .slot_start (w_slot_start),
    .bclk_rise  (w_bclk_rise_unused)
  );

  always_comb begin
    w_slot_next = r_slot + SLOT_W'(1);
    w_accept    = sample_valid && r_ready;
    // Leaving slot 0 is the frame load point.
    w_load      = w_slot_start && (r_slot == '0);
    // Load sees the buffer state before this edge; a same-cycle accept is too late.
    w_frame     = r_ready ? '0 : frame_word(r_buf);
  end

  // Holding buffer: r_ready doubles as the buffer-empty flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_buf      <= '0;
      r_ready    <= 1'b1;
      r_underrun <= 1'b0;
    end else begin
      r_underrun <= w_load && r_ready;
      if (w_accept) begin
        r_buf.left  <= left_in;
        r_buf.right <= right_in;
        r_ready     <= 1'b0;
      end else if (w_load) begin
        r_ready <= 1'b1;
      end
    end
  end

  // Slot counter and shifter. After a load the shifter keeps 63 bits, which
  // slots 2..63 and slot 0 of the next frame consume; slot 0 thus carries the
  // previous right LSB.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_slot  <= '0;
      r_shift <= '0;
      r_lrck  <= 1'b0;
      r_dat   <= 1'b0;
    end else if (w_slot_start) begin
      r_slot <= w_slot_next;
      r_lrck <= (w_slot_next >= SLOT_W'(LEFT_SLOTS));
      if (w_load) begin
        r_dat   <= w_frame[FRAME_W-1];
        r_shift <= {w_frame[FRAME_W-2:0], 1'b0};
      end else begin
        r_dat   <= r_shift[FRAME_W-1];
        r_shift <= {r_shift[FRAME_W-2:0], 1'b0};
      end
    end
  end

  assign sample_ready = r_ready;
  assign aud_daclrck  = r_lrck;
  assign aud_dacdat   = r_dat;
  assign underrun     = r_underrun;

endmodule

// File: tb/tb_i2s_dac_serializer.sv
// tb/tb_i2s_dac_serializer.sv - self-checking bench for i2s_dac_serializer
module tb_i2s_dac_serializer;

  localparam int CLK_DIV = 2;
  localparam int SLOT    = 2 * CLK_DIV;
  localparam int FRAME   = 64 * SLOT;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] left_in = '0;
  logic [31:0] right_in = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        aud_bclk;
  logic        aud_daclrck;
  logic        aud_dacdat;
  logic        underrun;

  int checks = 0;
  int failures = 0;

  // Reference model state: k = clk edges since reset release.
  int          k;
  int          n_acc;
  int          n_und;
  logic        m_full;
  logic        m_underrun;
  logic [63:0] m_buf;
  logic [63:0] frames[$];
  logic [63:0] cap[8];

  i2s_dac_serializer #(.CLK_DIV(CLK_DIV)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .left_in      (left_in),
    .right_in     (right_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .aud_bclk     (aud_bclk),
    .aud_daclrck  (aud_daclrck),
    .aud_dacdat   (aud_dacdat),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] obs();
    return {aud_bclk, aud_daclrck, aud_dacdat, sample_ready, underrun};
  endfunction

  // Expected outputs from slot arithmetic: global slot g = k / SLOT,
  // slot g >= 1 carries frame (g-1)/64, bit 63 - (g-1)%64.
  function automatic logic [4:0] exp_vec();
    int   g;
    int   n;
    logic d;
    g = k / SLOT;
    d = 1'b0;
    if (g >= 1) begin
      n = (g - 1) / 64;
      if (n < frames.size()) d = frames[n][63 - ((g - 1) % 64)];
    end
    return {(k % SLOT) >= CLK_DIV, (g % 64) >= 32, d, !m_full, m_underrun};
  endfunction

  task automatic do_reset();
    resetn       = 1'b0;
    sample_valid = 1'b0;
    left_in      = '0;
    right_in     = '0;
    repeat (2) @(negedge clk);
    k = 0; n_acc = 0; n_und = 0;
    m_full = 1'b0; m_underrun = 1'b0; m_buf = '0;
    frames.delete();
    for (int i = 0; i < 8; i++) cap[i] = '0;
    resetn = 1'b1;
  endtask

  // One clk: advance the model at the edge, then capture mid-slot data.
  task automatic step();
    logic acc;
    logic load;
    int   g;
    @(posedge clk);
    acc  = sample_valid && !m_full;
    k++;
    load = (k % FRAME) == SLOT;
    m_underrun = load && !m_full;
    if (load) begin
      frames.push_back(m_full ? m_buf : 64'd0);
      m_full = 1'b0;
    end
    if (acc) begin
      m_buf  = {left_in, right_in};
      m_full = 1'b1;
      n_acc++;
    end
    @(negedge clk);
    g = k / SLOT;
    if ((k % SLOT) == CLK_DIV && g >= 1 && (g - 1) / 64 < 8)
      cap[(g - 1) / 64][63 - ((g - 1) % 64)] = aud_dacdat;
    if (underrun) n_und++;
  endtask

  task automatic test_reset_idle();
    do_reset();
    checks++;
    if (obs() !== 5'b00010) begin
      failures++;
      $display("FAIL reset_values got=%b want=00010", obs());
    end
    for (int i = 0; i < 600; i++) begin
      step();
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL idle_cycle k=%0d got=%b want=%b", k, obs(), exp_vec());
      end
    end
    checks++;
    if (n_und !== 3) begin
      failures++;
      $display("FAIL idle_underrun_count got=%0d want=3", n_und);
    end
    checks++;
    if (cap[0] !== 64'd0 || cap[1] !== 64'd0) begin
      failures++;
      $display("FAIL idle_data got=%h/%h want=0", cap[0], cap[1]);
    end
  endtask

  task automatic test_single();
    do_reset();
    sample_valid = 1'b1;
    left_in      = 32'hA500_0001;
    right_in     = 32'h8000_0000;
    step();
    sample_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step();
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL single_cycle k=%0d got=%b want=%b", k, obs(), exp_vec());
      end
      if (k == 10) begin
        checks++;
        if (n_und !== 0) begin
          failures++;
          $display("FAIL single_no_underrun got=%0d want=0", n_und);
        end
      end
    end
    checks++;
    if (cap[0] !== 64'hA500_0001_8000_0000) begin
      failures++;
      $display("FAIL single_frame got=%h want=a500000180000000", cap[0]);
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] smp[4];
    int          idx;
    smp[0] = 64'h7FFF_FFFF_0000_0001;
    smp[1] = 64'h1234_5678_8765_4321;
    smp[2] = {$urandom(), $urandom()};
    smp[3] = {$urandom(), $urandom()};
    do_reset();
    idx = 0;
    sample_valid = 1'b1;
    {left_in, right_in} = smp[0];
    for (int i = 0; i < 1026; i++) begin
      step();
      if (n_acc > idx) begin
        idx = n_acc;
        if (idx < 4) {left_in, right_in} = smp[idx];
        else sample_valid = 1'b0;
      end
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL b2b_cycle k=%0d got=%b want=%b", k, obs(), exp_vec());
      end
      if (k == 260 || k == 516) begin
        checks++;
        if (sample_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_ready_after_load k=%0d got=%b want=1", k, sample_ready);
        end
      end
    end
    for (int f = 0; f < 4; f++) begin
      checks++;
      if (cap[f] !== smp[f]) begin
        failures++;
        $display("FAIL b2b_frame%0d got=%h want=%h", f, cap[f], smp[f]);
      end
    end
    checks++;
    if (n_und !== 0) begin
      failures++;
      $display("FAIL b2b_underrun got=%0d want=0", n_und);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] smp[3];
    int          idx;
    for (int i = 0; i < 3; i++) smp[i] = {$urandom(), $urandom()};
    do_reset();
    idx = 0;
    sample_valid = 1'b1;
    {left_in, right_in} = smp[0];
    for (int i = 0; i < 520; i++) begin
      step();
      if (n_acc > idx) begin
        idx = n_acc;
        if (idx < 3) {left_in, right_in} = smp[idx];
        else sample_valid = 1'b0;
      end
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL bp_cycle k=%0d got=%b want=%b", k, obs(), exp_vec());
      end
      if (k == 5 || k == 259 || k == 261) begin
        checks++;
        if (sample_ready !== 1'b0) begin
          failures++;
          $display("FAIL bp_ready_low k=%0d got=%b want=0", k, sample_ready);
        end
      end
    end
    checks++;
    if (cap[0] !== smp[0] || cap[1] !== smp[1]) begin
      failures++;
      $display("FAIL bp_frames got=%h/%h want=%h/%h", cap[0], cap[1], smp[0], smp[1]);
    end
  endtask

  task automatic test_collision();
    logic [63:0] s;
    s = {$urandom(), $urandom()} | 64'h8000_0000_0000_0001;
    do_reset();
    repeat (3) step();
    sample_valid = 1'b1;
    {left_in, right_in} = s;
    step();
    sample_valid = 1'b0;
    checks++;
    if (underrun !== 1'b1 || sample_ready !== 1'b0) begin
      failures++;
      $display("FAIL coll_load_cycle got=%b%b want=10", underrun, sample_ready);
    end
    for (int i = 0; i < 516; i++) begin
      step();
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL coll_cycle k=%0d got=%b want=%b", k, obs(), exp_vec());
      end
    end
    checks++;
    if (cap[0] !== 64'd0 || cap[1] !== s) begin
      failures++;
      $display("FAIL coll_frames got=%h/%h want=0/%h", cap[0], cap[1], s);
    end
  endtask

  task automatic test_mid_reset();
    logic [63:0] smp[2];
    int          idx;
    smp[0] = {$urandom(), $urandom()} | 64'h0000_0001_0000_0000;
    smp[1] = {$urandom(), $urandom()} | 64'h8000_0000_8000_0000;
    do_reset();
    idx = 0;
    sample_valid = 1'b1;
    {left_in, right_in} = smp[0];
    while (k < 40 * SLOT) begin
      step();
      if (n_acc > idx) begin
        idx = n_acc;
        if (idx < 2) {left_in, right_in} = smp[idx];
        else sample_valid = 1'b0;
      end
    end
    checks++;
    if (sample_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_buffer_full got=%b want=0", sample_ready);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if (obs() !== 5'b00010) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%b want=00010", obs());
    end
    do_reset();
    for (int i = 0; i < 300; i++) begin
      step();
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL mid_cycle k=%0d got=%b want=%b", k, obs(), exp_vec());
      end
    end
    checks++;
    if (cap[0] !== 64'd0 || n_und !== 2) begin
      failures++;
      $display("FAIL mid_discard got=%h und=%0d want=0 und=2", cap[0], n_und);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 800; i++) begin
      sample_valid = ($urandom_range(0, 3) == 0);
      left_in      = $urandom();
      right_in     = $urandom();
      step();
      checks++;
      if (obs() !== exp_vec()) begin
        failures++;
        $display("FAIL rand_cycle k=%0d got=%b want=%b", k, obs(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset_idle();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_collision();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2s_dac_serializer.md
# i2s_dac_serializer

Audio output end of the mixing chain. Accepts stereo 32-bit two's-complement, left-justified samples (the top level ties the mixer's 32-bit mix-down to both channels) over a valid/ready handshake. It buffers one stereo frame and serialises it MSB-first as an I2S master (bit clock, LR clock, serial data) to the board audio codec DAC. It flags underrun when no sample is available at a frame boundary.

## Interface
- CLK_DIV, 8, clk cycles per half bit-clock period; legal ≥2. At 50 MHz this gives a 3.125 MHz BCLK and a 48.8 kHz frame rate.
- clk  input  1  system clock; all logic on rising edge
- resetn  input  1  asynchronous, active-low reset
- left_in  input  32  left-channel sample, two's complement, MSB first on the wire
- right_in  input  32  right-channel sample
- sample_valid  input  1  left_in/right_in hold a sample
- sample_ready  output  1  holding buffer empty; transfer occurs when valid && ready
- aud_bclk  output  1  I2S bit clock
- aud_daclrck  output  1  LR clock; 0 = left, 1 = right
- aud_dacdat  output  1  serial data
- underrun  output  1  one-clk pulse when a frame loads with the buffer empty

## Operation
- Reset values: aud_bclk=0, aud_daclrck=0, aud_dacdat=0, sample_ready=1, underrun=0. Divider, slot counter and shift register are 0; the holding buffer is empty.
- A slot is 2·CLK_DIV clk cycles. The divider counts 0..2·CLK_DIV−1.
  - aud_bclk=0 for divider values 0..CLK_DIV−1 and 1 for the rest.
  - A slot boundary is the BCLK falling edge, where the divider wraps to 0.
- The slot counter s runs 0..63 and wraps to 0. aud_daclrck=0 for s=0..31 and 1 for s=32..63.
- Frame word F = {left, right} (64 bits). aud_dacdat during slot s:
  - s≥1: F bit (63−(s−1)).
  - s=0: the LSB of the previous frame's right channel, giving the I2S one-bit delay. This is 0 after reset.
- Frame load at the start of slot 1:
  - Buffer full: the shift register takes the buffer contents, and the buffer becomes empty.
  - Buffer empty: the shift register loads all zeros, and underrun pulses for that one clk.
- Handshake:
  - sample_ready = buffer empty (registered).
  - On valid && ready the buffer captures both channels and becomes full; ready drops on the next clk.
  - The load empties the buffer, and ready rises on the clk after the load.
  - A transfer in the load cycle itself is not visible to that load: the frame still loads zeros and flags underrun, and the buffer ends full for the next frame.
- sample_valid without ready: inputs ignored; nothing is dropped or overwritten.
- Async reset mid-frame: all outputs return to reset values immediately; the buffered sample is discarded. After release, slot 0 starts on the first clk edge.

## Timing
- Outputs are registered; aud_dacdat and aud_daclrck change only on the clk where aud_bclk falls. The codec samples on the BCLK rise, CLK_DIV clks later.
- Frame = 64 slots = 128·CLK_DIV clks.
- Latency from an accepted sample to its MSB on aud_dacdat is ≤ 1 frame + 1 slot. It is exact when accepted before the next slot-1 load.
- Throughput is one sample per frame; a producer that keeps valid asserted never underruns after the first frame.

## Structure
- Shared package audio_pkg: SAMPLE_W=32, FRAME_SLOTS=64, LEFT_SLOTS=32, and the two's-complement sample typedef used by the mixer and this block.
- One sub-module, i2s_bclk_gen: the divider, producing aud_bclk plus one-clk strobes slot_start (BCLK fall) and bclk_rise. The serializer FSM, buffer and shift register stay in the top module.

## Test plan
Each scenario uses CLK_DIV=2 (slot = 4 clks, frame = 256 clks).
1. Reset and idle: release resetn with no valid.
   - All outputs 0 and sample_ready=1 at release.
   - BCLK period is 4 clks; LRCK period is 256 clks, low for 128.
   - underrun pulses once per frame, at the start of slot 1.
   - aud_dacdat stays 0.
2. Single sample: left=32'hA5000001, right=32'h80000000, accepted before the first slot-1 load.
   - Slots 1..32 carry A5000001 MSB-first.
   - Slots 33..63 and slot 0 of the next frame carry 80000000.
   - No underrun is reported for that frame.
3. Back-to-back: valid held high with samples 32'h7FFFFFFF/32'h00000001, then 32'h12345678/32'h87654321.
   - Consecutive frames carry each sample exactly once.
   - ready falls after each accept and rises the clk after each load; underrun never pulses after the first frame.
4. Backpressure: buffer full and valid held with a new sample.
   - The buffer is not overwritten and the frame shows the old sample.
   - The new sample is accepted one clk after the load.
5. Collision: first accept occurs exactly in the slot-1 load cycle.
   - That frame transmits zeros and underrun pulses.
   - The sample appears in the following frame.
6. Mid-frame reset: assert resetn low at slot 40 with the buffer full.
   - Outputs go to 0 immediately.
   - After release, the next frame transmits zeros with underrun, proving the buffered sample was discarded.
